// File: rtl/program_loader.sv
// program_loader: streams little-endian bytes into 32-bit program-memory words while holding the core in reset
module program_loader #(
    parameter int MEMORY_DEPTH = 32,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start_i,
    input  logic [15:0]           Word_Count_i,
    input  logic [7:0]            Byte_i,
    input  logic                  Byte_Valid_i,
    output logic                  Byte_Ready_o,
    output logic                  Mem_Write_o,
    output logic [DATA_WIDTH-1:0] Mem_Address_o,
    output logic [DATA_WIDTH-1:0] Mem_Data_o,
    output logic                  Busy_o,
    output logic                  Done_o,
    output logic                  Error_o,
    output logic                  Cpu_Reset_o
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RECV  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam logic [16:0] DEPTH = 17'(MEMORY_DEPTH);

    logic [1:0]            state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [15:0]           idx_q, idx_d;
    logic [15:0]           count_q, count_d;
    logic [31:0]           word_q, word_d;
    logic                  error_q, error_d;
    logic                  ready_q, ready_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        idx_d      = idx_q;
        count_d    = count_q;
        word_d     = word_q;
        error_d    = error_q;
        if (state_q == IDLE) begin
            if (Start_i) begin
                count_d    = Word_Count_i;
                error_d    = 1'b0;
                byte_cnt_d = 2'd0;
                idx_d      = 16'd0;
                word_d     = 32'd0;
                if (Word_Count_i == 16'd0)
                    state_d = DONE;
                else if ({1'b0, Word_Count_i} > DEPTH)
                    error_d = 1'b1;
                else
                    state_d = RECV;
            end
        end else if (state_q == RECV) begin
            if (Byte_Valid_i) begin
                word_d[{byte_cnt_q, 3'b000} +: 8] = Byte_i;
                byte_cnt_d = byte_cnt_q + 2'd1;
                state_d    = (byte_cnt_q == 2'd3) ? WRITE : RECV;
            end
        end else if (state_q == WRITE) begin
            idx_d      = idx_q + 16'd1;
            byte_cnt_d = 2'd0;
            state_d    = (idx_d == count_q) ? DONE : RECV;
        end else begin
            state_d = IDLE;
        end
        // Outputs are registered from the next state so they line up with it
        ready_d = state_d == RECV;
        write_d = state_d == WRITE;
        busy_d  = state_d != IDLE;
        done_d  = state_d == DONE;
        addr_d  = write_d ? DATA_WIDTH'({idx_q, 2'b00}) : '0;
        data_d  = write_d ? DATA_WIDTH'(word_d) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            byte_cnt_q <= 2'd0;
            idx_q      <= 16'd0;
            count_q    <= 16'd0;
            word_q     <= 32'd0;
            error_q    <= 1'b0;
            ready_q    <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            word_q     <= word_d;
            error_q    <= error_d;
            ready_q    <= ready_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign Byte_Ready_o  = ready_q;
    assign Mem_Write_o   = write_q;
    assign Mem_Address_o = addr_q;
    assign Mem_Data_o    = data_q;
    assign Busy_o        = busy_q;
    assign Cpu_Reset_o   = busy_q;
    assign Done_o        = done_q;
    assign Error_o       = error_q;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven directed vectors plus hand-written reset-abort sequence
module tb_program_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start_i = 1'b0;
    logic [15:0] Word_Count_i = 16'd0;
    logic [7:0]  Byte_i = 8'd0;
    logic        Byte_Valid_i = 1'b0;
    logic        Byte_Ready_o, Mem_Write_o, Busy_o, Done_o, Error_o, Cpu_Reset_o;
    logic [31:0] Mem_Address_o, Mem_Data_o;

    int passed = 0;
    int total = 0;

    program_loader #(.MEMORY_DEPTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .Start_i(Start_i), .Word_Count_i(Word_Count_i),
        .Byte_i(Byte_i), .Byte_Valid_i(Byte_Valid_i), .Byte_Ready_o(Byte_Ready_o),
        .Mem_Write_o(Mem_Write_o), .Mem_Address_o(Mem_Address_o), .Mem_Data_o(Mem_Data_o),
        .Busy_o(Busy_o), .Done_o(Done_o), .Error_o(Error_o), .Cpu_Reset_o(Cpu_Reset_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [15:0] cnt;
        logic [7:0]  b;
        logic        v;
        logic [69:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [69:0] e(logic rdy, logic wr, logic [31:0] addr, logic [31:0] data,
                                      logic busy, logic done, logic err);
        return {rdy, wr, addr, data, busy, busy, done, err};
    endfunction

    function automatic vec_t mk(logic start, logic [15:0] cnt, logic [7:0] b, logic v, logic [69:0] exp);
        vec_t r;
        r.start = start; r.cnt = cnt; r.b = b; r.v = v; r.exp = exp;
        return r;
    endfunction

    function automatic logic [69:0] outs();
        return {Byte_Ready_o, Mem_Write_o, Mem_Address_o, Mem_Data_o, Busy_o, Cpu_Reset_o, Done_o, Error_o};
    endfunction

    task automatic chk(string name, logic [69:0] exp);
        logic [69:0] act;
        act = outs();
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got rdy,wr,addr,data,busy,cpu,done,err=%h required %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic start, logic [15:0] cnt, logic [7:0] b, logic v);
        Start_i = start; Word_Count_i = cnt; Byte_i = b; Byte_Valid_i = v;
    endtask

    localparam logic [69:0] IDLE_E = 70'd0;
    localparam logic [69:0] RECV_E = {1'b1, 1'b0, 64'd0, 4'b1100};

    initial begin
        // two-word back-to-back session; byte offered during WRITE must be ignored
        tbl.push_back(mk(1, 16'd2, 8'h00, 0, RECV_E));
        tbl.push_back(mk(0, 16'd0, 8'h13, 1, RECV_E));
        tbl.push_back(mk(0, 16'd0, 8'h00, 1, RECV_E));
        tbl.push_back(mk(0, 16'd0, 8'h00, 1, RECV_E));
        tbl.push_back(mk(0, 16'd0, 8'h00, 1, e(0, 1, 32'h0, 32'h00000013, 1, 0, 0)));
        tbl.push_back(mk(0, 16'd0, 8'hAA, 1, RECV_E));
        tbl.push_back(mk(0, 16'd0, 8'h93, 1, RECV_E));
        tbl.push_back(mk(0, 16'd0, 8'h00, 1, RECV_E));
        tbl.push_back(mk(0, 16'd0, 8'h10, 1, RECV_E));
        tbl.push_back(mk(0, 16'd0, 8'h00, 1, e(0, 1, 32'h4, 32'h00100093, 1, 0, 0)));
        tbl.push_back(mk(0, 16'd0, 8'h00, 0, e(0, 0, 0, 0, 1, 1, 0)));
        tbl.push_back(mk(0, 16'd0, 8'h55, 1, IDLE_E));
        // zero-count session
        tbl.push_back(mk(1, 16'd0, 8'h00, 0, e(0, 0, 0, 0, 1, 1, 0)));
        tbl.push_back(mk(0, 16'd0, 8'h00, 0, IDLE_E));
        // oversize count rejected, error sticky until next accepted start
        tbl.push_back(mk(1, 16'd33, 8'h00, 0, e(0, 0, 0, 0, 0, 0, 1)));
        tbl.push_back(mk(0, 16'd0, 8'h66, 1, e(0, 0, 0, 0, 0, 0, 1)));
        tbl.push_back(mk(1, 16'd1, 8'h00, 0, RECV_E));
        // valid gaps of 3 cycles, plus a Start_i during RECV that must be ignored
        tbl.push_back(mk(0, 16'd0, 8'h00, 0, RECV_E));
        tbl.push_back(mk(0, 16'd0, 8'h00, 0, RECV_E));
        tbl.push_back(mk(0, 16'd0, 8'h00, 0, RECV_E));
        tbl.push_back(mk(0, 16'd0, 8'h11, 1, RECV_E));
        tbl.push_back(mk(0, 16'd0, 8'h00, 0, RECV_E));
        tbl.push_back(mk(1, 16'd5, 8'h00, 0, RECV_E));
        tbl.push_back(mk(0, 16'd0, 8'h00, 0, RECV_E));
        tbl.push_back(mk(0, 16'd0, 8'h22, 1, RECV_E));
        tbl.push_back(mk(0, 16'd0, 8'h33, 1, RECV_E));
        tbl.push_back(mk(0, 16'd0, 8'h44, 1, e(0, 1, 32'h0, 32'h44332211, 1, 0, 0)));
        tbl.push_back(mk(0, 16'd0, 8'h00, 0, e(0, 0, 0, 0, 1, 1, 0)));
        tbl.push_back(mk(0, 16'd0, 8'h00, 0, IDLE_E));

        tick();
        tick();
        chk("reset_state", IDLE_E);
        reset = 1'b0;
        tick();
        chk("idle_after_reset", IDLE_E);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].start, tbl[i].cnt, tbl[i].b, tbl[i].v);
            tick();
            chk($sformatf("vec%0d", i), tbl[i].exp);
        end

        // maximum legal count accepted, then aborted by reset mid-word
        drive(1, 16'd32, 8'h00, 0);
        tick();
        chk("count32_accepted", RECV_E);
        drive(0, 16'd0, 8'hAB, 1);
        tick();
        drive(0, 16'd0, 8'hCD, 1);
        tick();
        chk("two_bytes_in", RECV_E);
        drive(0, 16'd0, 8'h00, 0);
        #2 reset = 1'b1;
        #1 chk("async_reset_zero", IDLE_E);
        drive(0, 16'd0, 8'hEF, 1);
        tick();
        chk("held_in_reset", IDLE_E);
        reset = 1'b0;
        tick();
        chk("no_accept_without_start1", IDLE_E);
        tick();
        chk("no_accept_without_start2", IDLE_E);
        drive(1, 16'd1, 8'h00, 0);
        tick();
        chk("restart", RECV_E);
        drive(0, 16'd0, 8'h78, 1);
        tick();
        drive(0, 16'd0, 8'h56, 1);
        tick();
        drive(0, 16'd0, 8'h34, 1);
        tick();
        drive(0, 16'd0, 8'h12, 1);
        tick();
        chk("restart_write", e(0, 1, 32'h0, 32'h12345678, 1, 0, 0));
        drive(0, 16'd0, 8'h00, 0);
        tick();
        chk("restart_done", e(0, 0, 0, 0, 1, 1, 0));
        tick();
        chk("restart_idle", IDLE_E);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
